// File: rtl/apb_master_32bit.sv
// APB4 requester: turns one valid/ready command into a single SETUP+ACCESS transfer
// and returns read data, slave error or timeout through a valid/ready response port.
module apb_master_32bit #(
    parameter int AddrBits      = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                p_clk,
    input  logic                p_resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AddrBits-1:0] cmd_addr,
    input  logic [31:0]         cmd_wdata,
    input  logic [3:0]          cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [AddrBits-1:0] p_addr,
    output logic                p_sel,
    output logic                p_enable,
    output logic                p_write,
    output logic [31:0]         p_wdata,
    output logic [3:0]          p_strb,
    input  logic [31:0]         p_rdata,
    input  logic                p_ready,
    input  logic                p_slverr
);

    localparam int CntBits = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state_reg, state_next;
    logic [CntBits-1:0]   wait_cnt_reg;
    logic                 accept;
    logic                 timeout_hit;

    logic                 cmd_ready_reg;
    logic                 rsp_valid_reg;
    logic [31:0]          rsp_rdata_reg;
    logic                 rsp_err_reg;
    logic                 rsp_timeout_reg;
    logic [AddrBits-1:0]  p_addr_reg;
    logic                 p_sel_reg;
    logic                 p_enable_reg;
    logic                 p_write_reg;
    logic [31:0]          p_wdata_reg;
    logic [3:0]           p_strb_reg;

    assign accept = cmd_valid & cmd_ready_reg;

    // The abort fires on the ACCESS cycle that would make the wait count reach TimeoutCycles,
    // so a dead slave sees exactly TimeoutCycles ACCESS cycles.
    generate
        if (TimeoutCycles > 0) begin : g_timeout
            assign timeout_hit = (wait_cnt_reg == CntBits'(TimeoutCycles - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (p_ready || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every port-facing control bit is registered from the next state so the bus sees clean edges.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            p_addr_reg      <= '0;
            p_sel_reg       <= 1'b0;
            p_enable_reg    <= 1'b0;
            p_write_reg     <= 1'b0;
            p_wdata_reg     <= '0;
            p_strb_reg      <= '0;
            wait_cnt_reg    <= '0;
        end else begin
            cmd_ready_reg <= (state_next == IDLE);
            p_sel_reg     <= (state_next == SETUP) || (state_next == ACCESS);
            p_enable_reg  <= (state_next == ACCESS);
            rsp_valid_reg <= (state_next == RESP);

            if (state_reg == IDLE && accept) begin
                p_addr_reg   <= cmd_addr;
                p_write_reg  <= cmd_write;
                p_wdata_reg  <= cmd_wdata;
                p_strb_reg   <= cmd_write ? cmd_strb : 4'b0000;
                wait_cnt_reg <= '0;
            end

            if (state_reg == ACCESS) begin
                if (p_ready) begin
                    rsp_rdata_reg   <= p_write_reg ? 32'h0 : p_rdata;
                    rsp_err_reg     <= p_slverr;
                    rsp_timeout_reg <= 1'b0;
                    p_strb_reg      <= 4'b0000;
                end else if (timeout_hit) begin
                    rsp_rdata_reg   <= 32'h0;
                    rsp_err_reg     <= 1'b1;
                    rsp_timeout_reg <= 1'b1;
                    p_strb_reg      <= 4'b0000;
                end else if (wait_cnt_reg != '1) begin
                    wait_cnt_reg <= wait_cnt_reg + CntBits'(1);
                end
            end
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign p_addr      = p_addr_reg;
    assign p_sel       = p_sel_reg;
    assign p_enable    = p_enable_reg;
    assign p_write     = p_write_reg;
    assign p_wdata     = p_wdata_reg;
    assign p_strb      = p_strb_reg;

endmodule

// File: tb/tb_apb_master_32bit.sv
// Bench for apb_master_32bit: directed plus random transfers against a memory-backed APB
// slave; expected responses come from a transaction-level reference memory.
module tb_apb_master_32bit;

    localparam int TO = 16;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        bit          err;
        int          rsp_delay;
        bit          chain;
    } txn_t;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] p_addr;
    logic        p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic [31:0] p_rdata = '0;
    logic        p_ready = 1'b0;
    logic        p_slverr = 1'b0;

    apb_master_32bit #(.AddrBits(32), .TimeoutCycles(TO)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .p_addr(p_addr), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_wdata(p_wdata), .p_strb(p_strb), .p_rdata(p_rdata),
        .p_ready(p_ready), .p_slverr(p_slverr)
    );

    always #5 p_clk = ~p_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    int          plan_waits = 0;
    bit          plan_err = 1'b0;
    int          acc_cnt = 0;
    txn_t        txns[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave: answers after plan_waits wait states; outside ACCESS its outputs are noise.
    always @(negedge p_clk) begin
        if (p_sel && p_enable) begin
            if (acc_cnt == plan_waits) begin
                p_ready  = 1'b1;
                p_slverr = plan_err;
                p_rdata  = slv_mem[p_addr[5:2]];
                if (p_write && !plan_err)
                    for (int b = 0; b < 4; b++)
                        if (p_strb[b]) slv_mem[p_addr[5:2]][8*b +: 8] = p_wdata[8*b +: 8];
            end else begin
                p_ready  = 1'b0;
                p_slverr = 1'($urandom);
                p_rdata  = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt  = 0;
            p_ready  = 1'($urandom);
            p_slverr = 1'($urandom);
            p_rdata  = $urandom;
        end
    end

    task automatic do_txn(input int id, input txn_t t, input bit chained_in,
                          input bit chain_out, input txn_t nx);
        bit          tmo;
        int          exp_acc;
        logic [31:0] exp_rdata;
        bit          exp_err;
        logic [3:0]  exp_strb;
        int          idx;
        int          tries;
        int          n;
        int          acc;
        int          bus_bad;
        int          hold_bad;
        bit          accepted;
        bit          rdy_now;

        idx       = int'(t.addr[5:2]);
        tmo       = (t.waits >= TO);
        exp_acc   = tmo ? TO : t.waits + 1;
        exp_rdata = (t.write || tmo) ? 32'h0 : ref_mem[idx];
        exp_err   = tmo ? 1'b1 : t.err;
        exp_strb  = t.write ? t.strb : 4'b0000;
        if (t.write && !tmo && !t.err)
            for (int b = 0; b < 4; b++)
                if (t.strb[b]) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
        plan_waits = t.waits;
        plan_err   = t.err;

        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_strb  = t.strb;
        rsp_ready = 1'($urandom);
        tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 50) begin
            rdy_now = cmd_ready;
            tries++;
            @(posedge p_clk);
            if (rdy_now) accepted = 1'b1;
            else @(negedge p_clk);
        end
        check("accept", 32'(accepted), 32'd1);
        if (!accepted) $fatal(1, "command never accepted");
        if (chained_in) check("b2b_setup_gap", tries, 1);

        n = 0;
        acc = 0;
        bus_bad = 0;
        while (1) begin
            @(negedge p_clk);
            n++;
            if (n == 1) begin
                cmd_valid = 1'b0;
                cmd_wdata = $urandom;
                cmd_addr  = $urandom;
                cmd_strb  = 4'($urandom);
                rsp_ready = 1'b0;
                check("setup_sel_en", {p_sel, p_enable}, 2'b10);
                check("setup_addr", p_addr, t.addr);
                check("setup_write", p_write, t.write);
                check("setup_wdata", p_wdata, t.wdata);
                check("setup_strb", p_strb, exp_strb);
            end else if (p_sel && p_enable) begin
                acc++;
                if (p_addr !== t.addr || p_write !== t.write || p_wdata !== t.wdata ||
                    p_strb !== exp_strb || cmd_ready !== 1'b0) bus_bad++;
            end
            if (rsp_valid === 1'b1 || n > 40) break;
        end
        check("rsp_latency", n, 2 + exp_acc);
        check("access_cycles", acc, exp_acc);
        check("access_stable", bus_bad, 0);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_timeout", rsp_timeout, tmo);
        check("resp_bus_idle", {p_sel, p_enable, cmd_ready, p_strb}, 0);
        check("resp_addr_kept", p_addr, t.addr);

        if (chain_out) begin
            cmd_valid = 1'b1;
            cmd_write = nx.write;
            cmd_addr  = nx.addr;
            cmd_wdata = nx.wdata;
            cmd_strb  = nx.strb;
        end
        hold_bad = 0;
        for (int k = 0; k < t.rsp_delay; k++) begin
            @(negedge p_clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
                rsp_timeout !== tmo || cmd_ready !== 1'b0 || p_sel !== 1'b0) hold_bad++;
        end
        check("rsp_hold", hold_bad, 0);

        rsp_ready = 1'b1;
        @(posedge p_clk);
        @(negedge p_clk);
        rsp_ready = 1'b0;
        check("rsp_drop", {rsp_valid, cmd_ready, p_sel}, 3'b010);
        $display("txn %0d: %s addr=%h waits=%0d rdata=%h err=%0d tmo=%0d lat=%0d",
                 id, t.write ? "WR" : "RD", t.addr, t.waits, rsp_rdata, rsp_err, rsp_timeout, n);
    endtask

    function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int wt, input bit e,
                                input int dl, input bit ch);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = d; t.strb = s;
        t.waits = wt; t.err = e; t.rsp_delay = dl; t.chain = ch;
        return t;
    endfunction

    initial begin
        txn_t t;
        bit   prev_chain;
        bit   co;

        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end

        repeat (2) @(negedge p_clk);
        check("reset_ctrl", {p_sel, p_enable, rsp_valid, cmd_ready, rsp_err, rsp_timeout}, 0);
        check("reset_bus", {p_strb, p_write}, 0);
        check("reset_addr", p_addr, 0);
        p_resetn = 1'b1;
        @(negedge p_clk);
        check("reset_release_ready", cmd_ready, 1);

        txns.push_back(mk(1, 32'h10, 32'hA5A5_1234, 4'b0011, 0, 0, 0, 0));
        txns.push_back(mk(0, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0));
        txns.push_back(mk(0, 32'h10, 32'h0, 4'b0000, 3, 1, 1, 0));
        txns.push_back(mk(1, 32'h24, 32'h1111_2222, 4'b1111, 1000, 0, 0, 0));
        txns.push_back(mk(1, 32'h28, 32'h3344_5566, 4'b1100, 15, 0, 0, 0));
        txns.push_back(mk(0, 32'h28, 32'h0, 4'b0000, 0, 0, 5, 1));
        txns.push_back(mk(0, 32'h24, 32'h0, 4'b0000, 2, 0, 0, 0));
        for (int i = 0; i < 40; i++) begin
            t.write     = 1'($urandom);
            t.addr      = $urandom & 32'hFFFF_FFFC;
            t.wdata     = $urandom;
            t.strb      = 4'($urandom);
            t.waits     = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
            t.err       = ($urandom_range(0, 4) == 0);
            t.rsp_delay = $urandom_range(0, 3);
            t.chain     = ($urandom_range(0, 2) == 0);
            txns.push_back(t);
        end

        prev_chain = 1'b0;
        for (int i = 0; i < txns.size(); i++) begin
            co = txns[i].chain && txns[i].rsp_delay > 0 && (i + 1 < txns.size());
            do_txn(i, txns[i], prev_chain, co, (i + 1 < txns.size()) ? txns[i + 1] : txns[i]);
            prev_chain = co;
        end

        // Asynchronous reset in the middle of a stalled ACCESS phase.
        plan_waits = 8;
        plan_err   = 1'b0;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h30;
        @(posedge p_clk);
        @(negedge p_clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge p_clk);
        check("rst_pre_access", {p_sel, p_enable}, 2'b11);
        #2 p_resetn = 1'b0;
        #1 check("rst_async_clear", {p_sel, p_enable, rsp_valid, cmd_ready}, 0);
        @(negedge p_clk);
        p_resetn = 1'b1;
        @(negedge p_clk);
        check("rst_release_ready", cmd_ready, 1);
        do_txn(txns.size(), mk(0, 32'h28, 32'h0, 4'b0000, 1, 0, 0, 0), 1'b0, 1'b0,
               mk(0, 32'h28, 32'h0, 4'b0000, 1, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
